play_ctrl: RTL and testbench

Front-end controller for the music player stage. It conditions raw push-buttons, runs the play/pause/stop state machine and tracks the selected song. It also generates the 4 Hz beat clock and a restart pulse. Its outputs drive the player's `Clock4Hz`, `en`, `sel_song` and active-low `reset` inputs directly.

---
 rtl/play_ctrl.sv | 159 +++++++++++++++
 tb/tb_play_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/play_ctrl.sv
// Music player front-end: button conditioning, play/pause/stop FSM, song select,
// beat clock generation and player restart pulse.
module play_ctrl #(
  parameter int unsigned CLK_HZ    = 6_000_000,
  parameter int unsigned BEAT_HZ   = 4,
  parameter int unsigned DEB_MS    = 20,
  parameter int unsigned NUM_SONGS = 3,
  parameter int unsigned RST_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_play,
  input  logic       btn_stop,
  input  logic       btn_next,
  input  logic       btn_prev,
  output logic       clock4hz,
  output logic       en,
  output logic [1:0] sel_song,
  output logic       play_rst_n,
  output logic [1:0] state
);

  localparam int unsigned NB      = 4;
  localparam int unsigned DEB_CYC = CLK_HZ / 1000 * DEB_MS;
  localparam int unsigned DEB_W   = $clog2(DEB_CYC + 1);
  localparam int unsigned HALF    = CLK_HZ / (2 * BEAT_HZ);
  localparam int unsigned BEAT_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned RST_W   = $clog2(RST_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYC - 1);
  localparam logic [BEAT_W-1:0] HALF_MAX = BEAT_W'(HALF - 1);
  localparam logic [RST_W-1:0]  RST_MAX  = RST_W'(RST_CYC - 1);
  localparam logic [1:0]        SONG_MAX = 2'(NUM_SONGS - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Button bit order: 0 play, 1 stop, 2 next, 3 prev
  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    sync1, sync2, deb, deb_d, press;
  logic [DEB_W-1:0] deb_cnt [NB];

  assign btn_raw = {btn_prev, btn_next, btn_stop, btn_play};

  // Synchronise, debounce and detect press edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            deb[i]     <= ~deb[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Priority decode: stop > next > prev > play
  logic ev_stop, ev_next, ev_prev, ev_play, restart_c;
  assign ev_stop   = press[1];
  assign ev_next   = press[2] & ~press[1];
  assign ev_prev   = press[3] & ~press[2] & ~press[1];
  assign ev_play   = press[0] & ~(|press[3:1]);
  assign restart_c = |press[3:1];

  state_t     state_q, state_d;
  logic [1:0] sel_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_STOP;
      en       <= 1'b0;
      sel_song <= 2'd0;
    end else begin
      state_q  <= state_d;
      en       <= (state_d == ST_PLAY);
      sel_song <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_song;
    if (ev_stop) begin
      state_d = ST_STOP;
    end else if (ev_next) begin
      sel_d = (sel_song == SONG_MAX) ? 2'd0 : sel_song + 2'd1;
    end else if (ev_prev) begin
      sel_d = (sel_song == 2'd0) ? SONG_MAX : sel_song - 2'd1;
    end else if (ev_play) begin
      case (state_q)
        ST_STOP:  state_d = ST_PLAY;
        ST_PLAY:  state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_PLAY;
        default:  state_d = ST_STOP;
      endcase
    end
  end

  assign state = state_q;

  // Restart pulse: low for RST_CYC cycles after reset or any restart event
  logic [RST_W-1:0] rst_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_cnt    <= '0;
      play_rst_n <= 1'b0;
    end else if (restart_c) begin
      rst_cnt    <= '0;
      play_rst_n <= 1'b0;
    end else if (!play_rst_n) begin
      if (rst_cnt == RST_MAX) begin
        rst_cnt    <= '0;
        play_rst_n <= 1'b1;
      end else begin
        rst_cnt <= rst_cnt + 1'b1;
      end
    end
  end

  // Beat divider, held cleared through restart so the first edge aligns to song start
  logic [BEAT_W-1:0] beat_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
      clock4hz <= 1'b0;
    end else if (restart_c || !play_rst_n) begin
      beat_cnt <= '0;
      clock4hz <= 1'b0;
    end else if (beat_cnt == HALF_MAX) begin
      beat_cnt <= '0;
      clock4hz <= ~clock4hz;
    end else begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_play_ctrl.sv
// Directed bench for play_ctrl at CLK_HZ=1000, DEB_MS=5, BEAT_HZ=50 (DEB_CYC=5, HALF=10).
module tb_play_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_play, btn_stop, btn_next, btn_prev;
  logic       clock4hz, en, play_rst_n;
  logic [1:0] sel_song, state;

  int checks = 0;
  int errors = 0;

  play_ctrl #(
    .CLK_HZ(1000), .BEAT_HZ(50), .DEB_MS(5), .NUM_SONGS(3), .RST_CYC(4)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_play(btn_play), .btn_stop(btn_stop), .btn_next(btn_next), .btn_prev(btn_prev),
    .clock4hz(clock4hz), .en(en), .sel_song(sel_song),
    .play_rst_n(play_rst_n), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask bits: 0 play, 1 stop, 2 next, 3 prev
  task automatic set_btns(input logic [3:0] m);
    {btn_prev, btn_next, btn_stop, btn_play} = m;
  endtask

  task automatic count_toggles(input int n, output int t);
    logic prev;
    t = 0;
    prev = clock4hz;
    for (int k = 0; k < n; k++) begin
      step(1);
      if (clock4hz != prev) t++;
      prev = clock4hz;
    end
  endtask

  // Hold buttons 20 cycles, release, settle 15; count restart-low cycles and beat-high-in-restart
  task automatic press_btn(input logic [3:0] m, output int low_cyc, output int hi_in_rst);
    low_cyc = 0;
    hi_in_rst = 0;
    set_btns(m);
    for (int k = 0; k < 35; k++) begin
      if (k == 20) set_btns(4'b0000);
      step(1);
      if (!play_rst_n) low_cyc++;
      if (!play_rst_n && clock4hz) hi_in_rst++;
    end
  endtask

  int tg, lo, hi;

  initial begin
    reset = 1'b0;
    set_btns(4'b0000);
    step(3);
    check("rst_state", 32'(state), 0);
    check("rst_en", 32'(en), 0);
    check("rst_sel", 32'(sel_song), 0);
    check("rst_play_rst_n", 32'(play_rst_n), 0);
    check("rst_clock4hz", 32'(clock4hz), 0);

    reset = 1'b1;
    step(3);
    check("rel_prn_c3", 32'(play_rst_n), 0);
    step(1);
    check("rel_prn_c4", 32'(play_rst_n), 1);
    step(9);
    check("beat_c13", 32'(clock4hz), 0);
    step(1);
    check("beat_c14", 32'(clock4hz), 1);
    step(9);
    check("beat_c23", 32'(clock4hz), 1);
    step(1);
    check("beat_c24", 32'(clock4hz), 0);
    step(76);
    check("idle_state", 32'(state), 0);
    check("idle_en", 32'(en), 0);
    check("idle_sel", 32'(sel_song), 0);

    // Play press latency: 2 + 5 + 1 + 1
    set_btns(4'b0001);
    step(8);
    check("play_c8_state", 32'(state), 0);
    check("play_c8_en", 32'(en), 0);
    step(1);
    check("play_c9_state", 32'(state), 1);
    check("play_c9_en", 32'(en), 1);
    step(11);
    set_btns(4'b0000);
    step(15);
    check("play_hold_state", 32'(state), 1);

    // Second press pauses; beat keeps running
    set_btns(4'b0001);
    step(9);
    check("pause_state", 32'(state), 2);
    check("pause_en", 32'(en), 0);
    step(11);
    set_btns(4'b0000);
    step(15);
    count_toggles(40, tg);
    check("pause_toggles", 32'(tg), 4);

    // Bounces shorter than the debounce window
    for (int r = 0; r < 5; r++) begin
      set_btns(4'b0001);
      step(3);
      set_btns(4'b0000);
      step(3);
    end
    step(20);
    check("glitch_state", 32'(state), 2);

    press_btn(4'b0001, lo, hi);
    check("resume_state", 32'(state), 1);
    check("resume_no_rst", 32'(lo), 0);

    // First next press in detail
    set_btns(4'b0100);
    step(8);
    check("next1_c8_sel", 32'(sel_song), 0);
    check("next1_c8_prn", 32'(play_rst_n), 1);
    step(1);
    check("next1_c9_sel", 32'(sel_song), 1);
    check("next1_c9_prn", 32'(play_rst_n), 0);
    check("next1_c9_beat", 32'(clock4hz), 0);
    check("next1_c9_en", 32'(en), 1);
    step(3);
    check("next1_c12_prn", 32'(play_rst_n), 0);
    check("next1_c12_beat", 32'(clock4hz), 0);
    step(1);
    check("next1_c13_prn", 32'(play_rst_n), 1);
    step(7);
    set_btns(4'b0000);
    step(15);

    press_btn(4'b0100, lo, hi);
    check("next2_sel", 32'(sel_song), 2);
    check("next2_low", 32'(lo), 4);
    check("next2_beat", 32'(hi), 0);
    check("next2_en", 32'(en), 1);
    press_btn(4'b0100, lo, hi);
    check("next3_sel", 32'(sel_song), 0);
    check("next3_low", 32'(lo), 4);
    check("next3_en", 32'(en), 1);

    press_btn(4'b1000, lo, hi);
    check("prev_wrap_sel", 32'(sel_song), 2);
    check("prev_low", 32'(lo), 4);
    check("prev_state", 32'(state), 1);

    // Stop and next together: stop wins, song unchanged, single restart
    press_btn(4'b0110, lo, hi);
    check("stopnext_state", 32'(state), 0);
    check("stopnext_sel", 32'(sel_song), 2);
    check("stopnext_low", 32'(lo), 4);
    check("stopnext_en", 32'(en), 0);

    // Reset during debounce
    set_btns(4'b0001);
    step(5);
    reset = 1'b0;
    #1;
    check("midrst_sel", 32'(sel_song), 0);
    check("midrst_prn", 32'(play_rst_n), 0);
    step(2);
    set_btns(4'b0000);
    reset = 1'b1;
    step(30);
    check("midrst_state", 32'(state), 0);
    check("midrst_en", 32'(en), 0);
    check("midrst_prn_rel", 32'(play_rst_n), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
